// File: rtl/sram_bus_master_pkg.sv
// sram_bus_master_pkg
//   Shared definitions for the SRAM strobe-bus master:
//   - state_e        : sequencer states of the strobe bus master
//   - WaitCntWidth   : width of the wait-state down-counter
//   - clamp_wait()   : maps a wait-state parameter into the legal 1..15 range
package sram_bus_master_pkg;

  localparam int WaitCntWidth = 4;
  localparam int WaitMax      = (1 << WaitCntWidth) - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_CAPTURE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    TURN
  } state_e;

  // Wait parameters of 0 behave as 1, and anything above the counter range
  // saturates, so a bad parameter never produces a zero-length strobe.
  function automatic logic [WaitCntWidth-1:0] clamp_wait(input int value);
    if (value < 1) begin
      return WaitCntWidth'(1);
    end else if (value > WaitMax) begin
      return WaitCntWidth'(WaitMax);
    end else begin
      return WaitCntWidth'(value);
    end
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
//   Loadable down-counter with a zero flag, used to time both the read access
//   window and the write-enable pulse.
//   Ports:
//     i_clk       system clock (rising edge)
//     i_rst       synchronous active-high reset, clears the count
//     i_load      load i_load_val (takes priority over decrement)
//     i_load_val  value to load
//     i_dec       decrement by one, saturating at zero
//     o_zero      count is zero
module sram_wait_counter
  import sram_bus_master_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [WaitCntWidth-1:0] i_load_val,
  input  logic                    i_dec,
  output logic                    o_zero
);

  logic [WaitCntWidth-1:0] count_q;
  logic [WaitCntWidth-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - WaitCntWidth'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/sram_bus_master.sv
// sram_bus_master
//   Synchronous initiator for an asynchronous 8-bit SRAM / dual-port RAM with
//   active-low strobes. Takes single read/write requests over valid/ready,
//   sequences ce_b/re_b/we_b with programmable wait states, and returns read
//   data (o_rd_valid pulse) or a write completion pulse (o_wr_done).
//   Ports:
//     i_clk, i_rst                 clock, synchronous active-high reset
//     i_req_valid/o_req_ready      request handshake (ready only when idle)
//     i_req_we/addr/wdata          request direction, address, write data
//     o_rd_valid/o_rd_data         read completion pulse and held read data
//     o_wr_done                    write completion pulse
//     o_ce_b/o_re_b/o_we_b         RAM strobes, active-low
//     o_addr                       registered RAM address
//     io_data                      RAM data bus, driven only during writes
//   Optional feature macro: SRAM_BUS_MASTER_BACK_TO_BACK_EN
//     When defined, a same-direction request may be accepted during TURN and
//     starts immediately, skipping the IDLE cycle.
module sram_bus_master
  import sram_bus_master_pkg::*;
#(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 8,
  parameter int ReadWait  = 2,
  parameter int WriteWait = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [AddrWidth-1:0] i_req_addr,
  input  logic [DataWidth-1:0] i_req_wdata,
  output logic                 o_rd_valid,
  output logic [DataWidth-1:0] o_rd_data,
  output logic                 o_wr_done,
  output logic                 o_ce_b,
  output logic                 o_re_b,
  output logic                 o_we_b,
  output logic [AddrWidth-1:0] o_addr,
  inout  wire  [DataWidth-1:0] io_data
);

  // Counter load values are one less than the wait length because the state
  // that watches the zero flag also spends the cycle in which zero is seen.
  localparam logic [WaitCntWidth-1:0] RdLoad = clamp_wait(ReadWait) - WaitCntWidth'(1);
  localparam logic [WaitCntWidth-1:0] WrLoad = clamp_wait(WriteWait) - WaitCntWidth'(1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d;

  logic                    req_ready;
  logic                    accept;
  logic                    drive_bus;
  logic                    cnt_load;
  logic [WaitCntWidth-1:0] cnt_load_val;
  logic                    cnt_dec;
  logic                    cnt_zero;

  sram_wait_counter u_wait_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  // Strobes are decoded straight from the state so that a reset returns them
  // high on the very next edge. Ready is masked by reset so nothing can be
  // accepted while the block is held in reset.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_done_d    = 1'b0;
    req_ready    = 1'b0;
    drive_bus    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = RdLoad;
    cnt_dec      = 1'b0;
    o_ce_b       = 1'b1;
    o_re_b       = 1'b1;
    o_we_b       = 1'b1;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      RD_ACCESS: begin
        o_ce_b  = 1'b0;
        o_re_b  = 1'b0;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = RD_CAPTURE;
        end
      end
      RD_CAPTURE: begin
        o_ce_b     = 1'b0;
        o_re_b     = 1'b0;
        rd_data_d  = io_data;
        rd_valid_d = 1'b1;
        state_d    = TURN;
      end
      WR_SETUP: begin
        o_ce_b       = 1'b0;
        drive_bus    = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = WrLoad;
        state_d      = WR_PULSE;
      end
      WR_PULSE: begin
        o_ce_b    = 1'b0;
        o_we_b    = 1'b0;
        drive_bus = 1'b1;
        cnt_dec   = 1'b1;
        if (cnt_zero) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        o_ce_b    = 1'b0;
        drive_bus = 1'b1;
        wr_done_d = 1'b1;
        state_d   = TURN;
      end
      TURN: begin
`ifdef SRAM_BUS_MASTER_BACK_TO_BACK_EN
        // Same direction needs no bus turnaround, so chain straight on.
        req_ready = (i_req_we == we_q);
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready = req_ready & ~i_rst;
    accept    = i_req_valid & req_ready;

    // Reads start their wait count on the accept edge; writes load theirs
    // in WR_SETUP.
    if (accept) begin
      addr_d   = i_req_addr;
      we_d     = i_req_we;
      wdata_d  = i_req_wdata;
      cnt_load = ~i_req_we;
      state_d  = i_req_we ? WR_SETUP : RD_ACCESS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign io_data     = drive_bus ? wdata_q : {DataWidth{1'bz}};
  assign o_req_ready = req_ready;
  assign o_addr      = addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_wr_done   = wr_done_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master
//   Scoreboard bench for sram_bus_master. A behavioural dual-port RAM sits on
//   the strobe bus (left port) with a bench-driven right port. Requests push
//   their expected completion into a queue; a monitor pops on every
//   completion pulse and also watches strobe invariants each cycle.
module tb_sram_bus_master;

  localparam int RW = 2;
  localparam int WW = 2;
`ifdef SRAM_BUS_MASTER_BACK_TO_BACK_EN
  localparam int RdPeriod = RW + 2;
`else
  localparam int RdPeriod = RW + 3;
`endif

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          exp_cyc;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_done;
  logic        ce_b;
  logic        re_b;
  logic        we_b;
  logic [15:0] ram_addr;
  wire  [7:0]  io_data;

  int   n_compared = 0;
  int   n_failed   = 0;
  int   cycle_cnt  = 0;
  int   pulse_cnt  = 0;
  int   re_run     = 0;
  int   we_run     = 0;
  txn_t sb[$];

  logic [7:0]  mem [65536];
  bit          written [65536];
  logic        rp_we;
  logic [15:0] rp_addr;
  logic [7:0]  rp_wdata;

  sram_bus_master #(
    .AddrWidth (16),
    .DataWidth (8),
    .ReadWait  (RW),
    .WriteWait (WW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_wr_done   (wr_done),
    .o_ce_b      (ce_b),
    .o_re_b      (re_b),
    .o_we_b      (we_b),
    .o_addr      (ram_addr),
    .io_data     (io_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Unwritten locations read back as the low address byte.
  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    return written[a] ? mem[a] : a[7:0];
  endfunction

  assign io_data = (!ce_b && !re_b) ? ram_rd(ram_addr) : 8'bz;

  // Right port has priority; left port writes while ce_b and we_b are low.
  always @(posedge clk) begin
    if (rp_we) begin
      mem[rp_addr]     <= rp_wdata;
      written[rp_addr] <= 1'b1;
    end else if (!ce_b && !we_b) begin
      mem[ram_addr]     <= io_data;
      written[ram_addr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: completion pulses against the scoreboard, plus bus invariants.
  always @(negedge clk) begin
    txn_t t;
    if (!ce_b || !re_b || !we_b) begin
      checkOutput("ready_while_busy", {31'b0, req_ready}, 32'd0);
      checkOutput("re_we_both_low", {31'b0, (!re_b && !we_b)}, 32'd0);
      if (sb.size() > 0) begin
        checkOutput("addr_stable", {16'b0, ram_addr}, {16'b0, sb[0].addr});
        if (!re_b) begin
          checkOutput("rd_bus", {24'b0, io_data}, {24'b0, ram_rd(sb[0].addr)});
        end
        if (sb[0].is_wr && re_b) begin
          checkOutput("wr_bus", {24'b0, io_data}, {24'b0, sb[0].data});
        end
      end
    end
    if (rst) begin
      re_run = 0;
      we_run = 0;
    end else begin
      if (!re_b) begin
        re_run++;
      end else if (re_run > 0) begin
        checkOutput("re_low_len", re_run, RW + 1);
        re_run = 0;
      end
      if (!we_b) begin
        we_run++;
      end else if (we_run > 0) begin
        checkOutput("we_low_len", we_run, WW);
        we_run = 0;
      end
    end
    if (rd_valid || wr_done) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        t = sb.pop_front();
        checkOutput("pulse_kind", {31'b0, wr_done}, {31'b0, t.is_wr});
        checkOutput("pulse_both", {31'b0, (rd_valid && wr_done)}, 32'd0);
        checkOutput("latency", cycle_cnt, t.exp_cyc);
        if (!t.is_wr) begin
          checkOutput("rd_data", {24'b0, rd_data}, {24'b0, t.data});
        end
      end
    end
  end

  // Issues one request and waits for it to be accepted; the expected
  // completion is queued with the cycle it must appear in.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] exp_rd, input bit hold, output int acc_idx);
    txn_t t;
    int   budget;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    budget = 50;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc_idx   = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_idx   = cycle_cnt;
    t.is_wr   = we;
    t.addr    = addr;
    t.data    = we ? wdata : exp_rd;
    t.exp_cyc = acc_idx + (we ? (WW + 2) : (RW + 1));
    sb.push_back(t);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int budget = 100;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int acc_list[4];
    int budget;
    int base;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rp_we     = 1'b0;
    rp_addr   = '0;
    rp_wdata  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_strobes", {29'b0, ce_b, re_b, we_b}, 32'd7);
    checkOutput("rst_addr", {16'b0, ram_addr}, 32'd0);
    checkOutput("rst_rd_data", {24'b0, rd_data}, 32'd0);
    checkOutput("rst_pulses", {30'b0, rd_valid, wr_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Basic read of the initial pattern.
    applyStimulus(1'b0, 16'h0123, 8'h00, 8'h23, 1'b0, acc);
    waitDrain();
    checkOutput("rd_data_hold", {24'b0, rd_data}, 32'h23);

    // Write then read back.
    applyStimulus(1'b1, 16'h0040, 8'hA5, 8'h00, 1'b0, acc);
    waitDrain();
    applyStimulus(1'b0, 16'h0040, 8'h00, 8'hA5, 1'b0, acc);
    waitDrain();

    // Valid held high with alternating direction.
    applyStimulus(1'b1, 16'h0010, 8'h3C, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 16'h0010, 8'h00, 8'h3C, 1'b1, acc);
    applyStimulus(1'b1, 16'h0011, 8'hC3, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 16'h0011, 8'h00, 8'hC3, 1'b1, acc);
    applyStimulus(1'b0, 16'h0200, 8'h00, 8'h00, 1'b0, acc);
    waitDrain();

    // Reset during the write-enable pulse aborts the access silently.
    applyStimulus(1'b1, 16'h0050, 8'h77, 8'h00, 1'b0, acc);
    budget = 20;
    while (we_b && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reach_wr_pulse", {31'b0, we_b}, 32'd0);
    rst  = 1'b1;
    base = pulse_cnt;
    @(posedge clk);
    #1;
    checkOutput("abort_strobes", {29'b0, ce_b, re_b, we_b}, 32'd7);
    checkOutput("abort_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("abort_rd_data", {24'b0, rd_data}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready_release", {31'b0, req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("abort_no_pulse", pulse_cnt - base, 32'd0);

    // Right port writes, master reads it through the left port.
    @(negedge clk);
    rp_we    = 1'b1;
    rp_addr  = 16'h03FF;
    rp_wdata = 8'h5A;
    @(negedge clk);
    rp_we = 1'b0;
    applyStimulus(1'b0, 16'h03FF, 8'h00, 8'h5A, 1'b0, acc);
    waitDrain();

    // Four consecutive reads: accept spacing shows back-to-back chaining.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h20A0 + 16'(i), 8'h00, 8'hA0 + 8'(i), 1'b1, acc_list[i]);
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checkOutput("rd_spacing", acc_list[i] - acc_list[i-1], RdPeriod);
    end
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
